// File: rtl/alu_req_arbiter.sv
// Purpose: two-requester round-robin arbiter and sequencer for the shared ALU, with response return and watchdog.
// Latency: accept at T, ALU_EN at T+1, response valid at T+3 (registered ALU) or T+TIMEOUT+2 on timeout.
// Backpressure: one command in flight; REQn_READY is low while busy, RSPn_VALID holds until RSPn_READY.
module alu_req_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int FUN_WIDTH  = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  REQ0_VALID,
    input  logic [DATA_WIDTH-1:0] REQ0_A,
    input  logic [DATA_WIDTH-1:0] REQ0_B,
    input  logic [FUN_WIDTH-1:0]  REQ0_FUN,
    output logic                  REQ0_READY,

    input  logic                  REQ1_VALID,
    input  logic [DATA_WIDTH-1:0] REQ1_A,
    input  logic [DATA_WIDTH-1:0] REQ1_B,
    input  logic [FUN_WIDTH-1:0]  REQ1_FUN,
    output logic                  REQ1_READY,

    output logic                  RSP0_VALID,
    input  logic                  RSP0_READY,
    output logic                  RSP1_VALID,
    input  logic                  RSP1_READY,
    output logic [OUT_WIDTH-1:0]  RSP_DATA,
    output logic                  RSP_ERR,

    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_EN,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VALID,

    output logic                  BUSY
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_last;
    logic                  r_owner;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [FUN_WIDTH-1:0]  r_alu_fun;
    logic                  r_alu_en;
    logic [OUT_WIDTH-1:0]  r_rsp_data;
    logic                  r_rsp_err;
    logic                  r_rsp0_vld;
    logic                  r_rsp1_vld;
    logic                  r_busy;

    logic                  w_idle;
    logic                  w_winner;
    logic                  w_accept;
    logic                  w_rsp_take;
    logic [DATA_WIDTH-1:0] w_sel_a;
    logic [DATA_WIDTH-1:0] w_sel_b;
    logic [FUN_WIDTH-1:0]  w_sel_fun;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle & (REQ0_VALID | REQ1_VALID);

    // Pick the winner: a lone requester wins outright, a tie goes to the one not served last.
    always_comb begin
        w_winner = 1'b0;
        if (REQ0_VALID && REQ1_VALID) begin
            w_winner = ~r_last;
        end else if (REQ1_VALID) begin
            w_winner = 1'b1;
        end
    end

    // Route the winning requester's command onto the latch inputs.
    always_comb begin
        w_sel_a   = REQ0_A;
        w_sel_b   = REQ0_B;
        w_sel_fun = REQ0_FUN;
        if (w_winner) begin
            w_sel_a   = REQ1_A;
            w_sel_b   = REQ1_B;
            w_sel_fun = REQ1_FUN;
        end
    end

    assign REQ0_READY = w_idle & REQ0_VALID & ~w_winner;
    assign REQ1_READY = w_idle & REQ1_VALID &  w_winner;

    // Only the owner's READY can close the response; the other port is ignored.
    assign w_rsp_take = r_owner ? RSP1_READY : RSP0_READY;

    // Sequencer: accept, issue one strobe, wait for the ALU or the watchdog, hold the response.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_fun  <= '0;
            r_alu_en   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp0_vld <= 1'b0;
            r_rsp1_vld <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_a   <= w_sel_a;
                        r_alu_b   <= w_sel_b;
                        r_alu_fun <= w_sel_fun;
                        r_owner   <= w_winner;
                        r_last    <= w_winner;
                        r_alu_en  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_alu_en <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (ALU_OUT_VALID) begin
                        r_rsp_data <= ALU_OUT;
                        r_rsp_err  <= 1'b0;
                        r_rsp0_vld <= ~r_owner;
                        r_rsp1_vld <=  r_owner;
                        r_state    <= S_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // The ALU never answered: return an error so the owner is not stuck.
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_rsp0_vld <= ~r_owner;
                        r_rsp1_vld <=  r_owner;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_take) begin
                        r_rsp0_vld <= 1'b0;
                        r_rsp1_vld <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ALU_A      = r_alu_a;
    assign ALU_B      = r_alu_b;
    assign ALU_FUN    = r_alu_fun;
    assign ALU_EN     = r_alu_en;
    assign RSP_DATA   = r_rsp_data;
    assign RSP_ERR    = r_rsp_err;
    assign RSP0_VALID = r_rsp0_vld;
    assign RSP1_VALID = r_rsp1_vld;
    assign BUSY       = r_busy;

endmodule
